// File: rtl/frame_composer_pkg.sv
// Shared types and constants for the frame redraw sequencer.
// Symbol width is shared with symbol_drawer and the text RAM.
package frame_composer_pkg;

    localparam int SYM_W = 7;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    localparam int DEF_TEXT_LEN    = 32;
    localparam int DEF_ORIGIN_X    = 0;
    localparam int DEF_ORIGIN_Y    = 200;
    localparam int DEF_CHAR_WIDTH  = 15;
    localparam int DEF_LINE_HEIGHT = 20;
    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_GO,
        S_FILL_WAIT,
        S_RD,
        S_LOAD,
        S_SYM_GO,
        S_SYM_WAIT,
        S_SWAP
    } state_t;

endpackage

// File: rtl/text_cursor_pos.sv
// Glyph index and pen position tracker.
// Advances x per glyph and wraps to a new line at the right edge.
module text_cursor_pos
    import frame_composer_pkg::*;
#(
    parameter int AW          = 5,
    parameter int ORIGIN_X    = DEF_ORIGIN_X,
    parameter int ORIGIN_Y    = DEF_ORIGIN_Y,
    parameter int CHAR_WIDTH  = DEF_CHAR_WIDTH,
    parameter int LINE_HEIGHT = DEF_LINE_HEIGHT,
    parameter int SCREEN_W    = DEF_SCREEN_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init_i,
    input  logic           advance_i,
    input  logic [AW:0]    len_i,
    output logic [AW:0]    idx_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    localparam logic [X_W-1:0] OX     = X_W'(ORIGIN_X);
    localparam logic [Y_W-1:0] OY     = Y_W'(ORIGIN_Y);
    localparam logic [X_W:0]   CW_EXT = (X_W+1)'(CHAR_WIDTH);
    localparam logic [X_W:0]   SW_EXT = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W-1:0] LH_Y   = Y_W'(LINE_HEIGHT);

    logic [AW:0]    idx_q, idx_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [AW:0]    idx_inc;
    logic [X_W:0]   x_next;
    logic [X_W:0]   x_edge;

    assign idx_inc = idx_q + {{AW{1'b0}}, 1'b1};
    // x arithmetic is one bit wider so the edge compare cannot overflow
    assign x_next  = {1'b0, x_q} + CW_EXT;
    assign x_edge  = x_next + CW_EXT;
    assign last_o  = (idx_inc == len_i);

    // next pen position: restart at origin, or step and wrap
    always_comb begin
        idx_d = idx_q;
        x_d   = x_q;
        y_d   = y_q;
        if (init_i) begin
            idx_d = '0;
            x_d   = OX;
            y_d   = OY;
        end else if (advance_i) begin
            idx_d = idx_inc;
            if (!last_o) begin
                if (x_edge > SW_EXT) begin
                    x_d = OX;
                    y_d = y_q + LH_Y;
                end else begin
                    x_d = x_next[X_W-1:0];
                end
            end
        end
    end

    // position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            x_q   <= OX;
            y_q   <= OY;
        end else begin
            idx_q <= idx_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign idx_o = idx_q;
    assign x_o   = x_q;
    assign y_o   = y_q;

endmodule

// File: rtl/frame_composer.sv
// Frame redraw sequencer: fill, then one glyph per text symbol, then swap.
// Drives drawer handshakes only; the frame buffer write port is not touched here.
module frame_composer
    import frame_composer_pkg::*;
#(
    parameter int TEXT_LEN    = DEF_TEXT_LEN,
    parameter int ORIGIN_X    = DEF_ORIGIN_X,
    parameter int ORIGIN_Y    = DEF_ORIGIN_Y,
    parameter int CHAR_WIDTH  = DEF_CHAR_WIDTH,
    parameter int LINE_HEIGHT = DEF_LINE_HEIGHT,
    parameter int SCREEN_W    = DEF_SCREEN_W,
    localparam int AW         = $clog2(TEXT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [AW:0]      text_len,
    input  logic [AW:0]      cursor_pos,
    output logic [AW-1:0]    text_addr,
    input  logic [SYM_W-1:0] text_data,
    output logic             fill_start,
    input  logic             fill_ready,
    output logic             sym_start,
    input  logic             sym_ready,
    output logic [X_W-1:0]   sym_x,
    output logic [Y_W-1:0]   sym_y,
    output logic [SYM_W-1:0] sym_symbol,
    output logic             sym_cursor_left,
    output logic             sym_cursor_right,
    output logic             swap
);

    state_t           state_q;
    logic             ready_q;
    logic             fill_start_q;
    logic             sym_start_q;
    logic             swap_q;
    logic             guard_q;
    logic [AW:0]      len_q;
    logic [AW:0]      cur_q;
    logic [SYM_W-1:0] symbol_q;
    logic             cl_q;
    logic             cr_q;

    logic        init;
    logic        advance;
    logic        last;
    logic [AW:0] idx;
    logic [AW:0] idx_inc;

    assign init    = (state_q == S_IDLE) && start;
    assign advance = (state_q == S_SYM_WAIT) && !guard_q && sym_ready;
    assign idx_inc = idx + {{AW{1'b0}}, 1'b1};

    text_cursor_pos #(
        .AW         (AW),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .CHAR_WIDTH (CHAR_WIDTH),
        .LINE_HEIGHT(LINE_HEIGHT),
        .SCREEN_W   (SCREEN_W)
    ) u_pos (
        .clk      (clk),
        .rst      (rst),
        .init_i   (init),
        .advance_i(advance),
        .len_i    (len_q),
        .idx_o    (idx),
        .x_o      (sym_x),
        .y_o      (sym_y),
        .last_o   (last)
    );

    // sequencing FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            fill_start_q <= 1'b0;
            sym_start_q  <= 1'b0;
            swap_q       <= 1'b0;
            guard_q      <= 1'b0;
            len_q        <= '0;
            cur_q        <= '0;
            symbol_q     <= '0;
            cl_q         <= 1'b0;
            cr_q         <= 1'b0;
        end else begin
            fill_start_q <= 1'b0;
            sym_start_q  <= 1'b0;
            swap_q       <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q        <= text_len;
                        cur_q        <= cursor_pos;
                        ready_q      <= 1'b0;
                        fill_start_q <= 1'b1;
                        state_q      <= S_FILL_GO;
                    end
                end
                S_FILL_GO: begin
                    guard_q <= 1'b1;
                    state_q <= S_FILL_WAIT;
                end
                S_FILL_WAIT: begin
                    // drawer ready may lag its start pulse by a cycle
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (fill_ready) begin
                        if (len_q == '0) begin
                            swap_q  <= 1'b1;
                            state_q <= S_SWAP;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    symbol_q    <= text_data;
                    cl_q        <= (cur_q == idx);
                    cr_q        <= (cur_q == idx_inc);
                    sym_start_q <= 1'b1;
                    state_q     <= S_SYM_GO;
                end
                S_SYM_GO: begin
                    guard_q <= 1'b1;
                    state_q <= S_SYM_WAIT;
                end
                S_SYM_WAIT: begin
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (sym_ready) begin
                        if (last) begin
                            swap_q  <= 1'b1;
                            state_q <= S_SWAP;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_SWAP: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready            = ready_q;
    assign text_addr        = idx[AW-1:0];
    assign fill_start       = fill_start_q;
    assign sym_start        = sym_start_q;
    assign sym_symbol       = symbol_q;
    assign sym_cursor_left  = cl_q;
    assign sym_cursor_right = cr_q;
    assign swap             = swap_q;

endmodule
